// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution stage.
package cond_pkg;

  // Instruction condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Bit positions inside the {N,Z,C,V} flags vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bit positions inside the flag_w request
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/condition_check.sv
// Combinational evaluation of a condition field against {N,Z,C,V}.
module condition_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  // Decode the condition field; 1111 is executed unconditionally like AL
  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV register, latched condition result,
// and gating of architectural writes.
module cond_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_latch,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic [3:0] flags,
  output logic       cond_ex,
  output logic       cond_ex_q,
  output logic       pcs_g,
  output logic       reg_w_g,
  output logic       mem_w_g
);

  // Condition is always judged on the stored flags, not the ALU's
  condition_check u_check (
    .Cond   (cond),
    .Flags  (flags),
    .CondEx (cond_ex)
  );

  // Flag halves and the latched result; flag writes use the old cond_ex_q,
  // so a capture and a flag write in one cycle do not interact
  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= RESET_FLAGS;
      cond_ex_q <= 1'b0;
    end else if (en) begin
      if (cond_latch)
        cond_ex_q <= cond_ex;
      if (flag_w[FW_NZ] && cond_ex_q)
        flags[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
      if (flag_w[FW_CV] && cond_ex_q)
        flags[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
    end
  end

  // Write enables gated by the latched result, no added latency
  always_comb begin
    pcs_g   = pcs & cond_ex_q;
    reg_w_g = reg_w & ~no_write & cond_ex_q;
    mem_w_g = mem_w & cond_ex_q;
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed plus random checks of cond_unit against a behavioural model.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset, en, cond_latch, pcs, reg_w, mem_w, no_write;
  logic [3:0] cond, alu_flags;
  logic [1:0] flag_w;
  logic [3:0] flags;
  logic       cond_ex, cond_ex_q, pcs_g, reg_w_g, mem_w_g;

  int errors = 0;
  int checks = 0;

  // Model state: architectural flags and the latched execute decision
  logic [3:0] m_flags;
  logic       m_q;

  always #5 clk = ~clk;

  cond_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(reset), .en(en), .cond(cond), .alu_flags(alu_flags),
    .cond_latch(cond_latch), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w),
    .mem_w(mem_w), .no_write(no_write), .flags(flags), .cond_ex(cond_ex),
    .cond_ex_q(cond_ex_q), .pcs_g(pcs_g), .reg_w_g(reg_w_g), .mem_w_g(mem_w_g)
  );

  // ARM condition semantics written from the mnemonic table
  function automatic bit passes(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combinational outputs against the model's current state
  task automatic chk_comb(input string tag);
    #1;
    chk({tag, ".cond_ex"}, {3'b0, cond_ex}, {3'b0, passes(cond, m_flags)});
    chk({tag, ".pcs_g"},   {3'b0, pcs_g},   {3'b0, pcs & m_q});
    chk({tag, ".reg_w_g"}, {3'b0, reg_w_g}, {3'b0, reg_w & !no_write & m_q});
    chk({tag, ".mem_w_g"}, {3'b0, mem_w_g}, {3'b0, mem_w & m_q});
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic tick(input string tag);
    logic nq;
    if (reset) begin
      m_flags = 4'b0000;
      m_q     = 1'b0;
    end else if (en) begin
      nq = cond_latch ? passes(cond, m_flags) : m_q;
      if (flag_w[1] && m_q) m_flags[3:2] = alu_flags[3:2];
      if (flag_w[0] && m_q) m_flags[1:0] = alu_flags[1:0];
      m_q = nq;
    end
    @(posedge clk);
    #1;
    chk({tag, ".flags"}, flags, m_flags);
    chk({tag, ".cond_ex_q"}, {3'b0, cond_ex_q}, {3'b0, m_q});
  endtask

  task automatic idle();
    reset = 0; en = 1; cond_latch = 0; flag_w = 2'b00;
    pcs = 0; reg_w = 0; mem_w = 0; no_write = 0;
  endtask

  initial begin
    m_flags = 4'bx; m_q = 1'bx;
    idle(); cond = 4'hE; alu_flags = 4'h0;

    // 1. reset then idle
    reset = 1; tick("rst");
    reset = 0; pcs = 1; reg_w = 1; mem_w = 1;
    cond = 4'h0; chk_comb("idle.eq");
    chk("idle.eq_lit", {3'b0, cond_ex}, 4'h0);
    chk("idle.pcs_g_lit", {pcs_g, reg_w_g, mem_w_g, 1'b0}, 4'h0);
    cond = 4'hE; chk_comb("idle.al");
    chk("idle.al_lit", {3'b0, cond_ex}, 4'h1);

    // 2. flag write under AL
    idle(); cond = 4'hE; cond_latch = 1; tick("p2.latch");
    cond_latch = 0; flag_w = 2'b11; alu_flags = 4'b0100; tick("p2.fw");
    chk("p2.flags_lit", flags, 4'b0100);
    flag_w = 2'b00;
    cond = 4'h1; chk_comb("p2.ne");
    chk("p2.ne_lit", {3'b0, cond_ex}, 4'h0);
    cond = 4'h0; chk_comb("p2.eq");
    chk("p2.eq_lit", {3'b0, cond_ex}, 4'h1);

    // 3. partial update of C,V only
    cond = 4'hE; flag_w = 2'b01; alu_flags = 4'b1011; tick("p3");
    chk("p3.flags_lit", flags, 4'b0111);

    // 4. suppressed instruction
    idle(); reset = 1; tick("p4.rst");
    reset = 0; cond = 4'h0; cond_latch = 1; tick("p4.latch");
    chk("p4.q_lit", {3'b0, cond_ex_q}, 4'h0);
    cond_latch = 0; flag_w = 2'b11; alu_flags = 4'hF; pcs = 1; reg_w = 1; mem_w = 1;
    chk_comb("p4.gated");
    chk("p4.gated_lit", {pcs_g, reg_w_g, mem_w_g, 1'b0}, 4'h0);
    tick("p4.fw");
    chk("p4.flags_lit", flags, 4'b0000);

    // 5. signed conditions
    idle(); cond = 4'hE; cond_latch = 1; tick("p5.latch");
    cond_latch = 0; flag_w = 2'b11; alu_flags = 4'b1001; tick("p5.fw1");
    flag_w = 2'b00;
    cond = 4'hA; chk_comb("p5.ge1"); chk("p5.ge1_lit", {3'b0, cond_ex}, 4'h1);
    cond = 4'hB; chk_comb("p5.lt1"); chk("p5.lt1_lit", {3'b0, cond_ex}, 4'h0);
    cond = 4'hC; chk_comb("p5.gt1"); chk("p5.gt1_lit", {3'b0, cond_ex}, 4'h1);
    cond = 4'hD; chk_comb("p5.le1"); chk("p5.le1_lit", {3'b0, cond_ex}, 4'h0);
    flag_w = 2'b01; alu_flags = 4'b0000; tick("p5.fw2");
    flag_w = 2'b00;
    chk("p5.flags_lit", flags, 4'b1000);
    cond = 4'hA; chk_comb("p5.ge2"); chk("p5.ge2_lit", {3'b0, cond_ex}, 4'h0);
    cond = 4'hB; chk_comb("p5.lt2"); chk("p5.lt2_lit", {3'b0, cond_ex}, 4'h1);
    cond = 4'hD; chk_comb("p5.le2"); chk("p5.le2_lit", {3'b0, cond_ex}, 4'h1);

    // 6. stall, reset with a pending result, no_write
    en = 0; cond = 4'h0; cond_latch = 1; flag_w = 2'b11; alu_flags = 4'b0110;
    tick("p6.stall");
    chk("p6.stall_lit", {cond_ex_q, flags[2:0]}, {1'b1, 3'b000});
    idle(); reset = 1; tick("p6.rst");
    chk("p6.rst_lit", {cond_ex_q, flags[2:0]}, 4'h0);
    reset = 0; cond = 4'hE; cond_latch = 1; tick("p6.latch");
    cond_latch = 0; reg_w = 1; no_write = 1; chk_comb("p6.nowrite");
    chk("p6.nowrite_lit", {3'b0, reg_w_g}, 4'h0);

    // Random traffic, occasional resets and stalls
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 31) == 0);
      en         = ($urandom_range(0, 7) != 0);
      cond       = 4'($urandom);
      alu_flags  = 4'($urandom);
      cond_latch = 1'($urandom);
      flag_w     = 2'($urandom);
      pcs        = 1'($urandom);
      reg_w      = 1'($urandom);
      mem_w      = 1'($urandom);
      no_write   = 1'($urandom);
      chk_comb("rnd.pre");
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution stage of the ARM calculator datapath; sits between the decoder/ALU and the register file, memory and PC write logic.
- Holds the architectural NZCV flags register.
- Evaluates the instruction condition field against the stored flags through a condition_check sub-module. Latches the result for the multicycle controller.
- Gates all architectural writes and flag updates with the latched condition result.

Parameters:
- RESET_FLAGS, 4'b0000, value loaded into the {N,Z,C,V} flags register on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  stage enable; 0 = hold all state (stall).
- cond  input  4  instruction condition field, Instr[31:28].
- alu_flags  input  4  ALU result flags {N,Z,C,V}.
- cond_latch  input  1  controller strobe: capture the condition result this cycle (decode state).
- flag_w  input  2  flag write request: [1] = N,Z; [0] = C,V.
- pcs  input  1  PC write request.
- reg_w  input  1  register-file write request.
- mem_w  input  1  memory write request.
- no_write  input  1  suppress the register write (CMP/CMN/TST/TEQ).
- flags  output  4  current flags register {N,Z,C,V}.
- cond_ex  output  1  combinational condition result from the current flags.
- cond_ex_q  output  1  latched condition result.
- pcs_g  output  1  pcs & cond_ex_q.
- reg_w_g  output  1  reg_w & ~no_write & cond_ex_q.
- mem_w_g  output  1  mem_w & cond_ex_q.

Behaviour:
- Reset (synchronous, active-high): flags <= RESET_FLAGS; cond_ex_q <= 0.
  - All gated outputs read 0 the cycle after reset is sampled.
  - cond_ex then reflects RESET_FLAGS.
  - Reset has priority over en and over every write request.
- cond_ex is combinational, evaluated on the flags register, never on alu_flags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 1 (treated as AL)
- Capture: if en & cond_latch, then cond_ex_q <= cond_ex at the next edge (1-cycle latency). Otherwise cond_ex_q holds.
- Flag update uses the latched result:
  - if en & flag_w[1] & cond_ex_q: {N,Z} <= alu_flags[3:2].
  - if en & flag_w[0] & cond_ex_q: {C,V} <= alu_flags[1:0].
  - The two halves update independently; unselected bits hold.
- Gated outputs are combinational from cond_ex_q and the request inputs. No extra latency.
- Simultaneous cond_latch and flag write in one cycle:
  - Flag write is qualified by the old cond_ex_q.
  - New cond_ex_q is computed from the pre-update flags.
  - Updated flags become visible on cond_ex the following cycle.
- en=0: flags and cond_ex_q hold. Gated outputs still follow their inputs combinationally; the controller deasserts requests during stalls.
- Reset mid-instruction: pending latched result is discarded (cond_ex_q=0), so no writes escape in the following cycles.
- no_write affects only reg_w_g. Flags still update for compare instructions.

Decomposition:
- Shared package cond_pkg:
  - condition code constants COND_EQ..COND_AL (4-bit).
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flag_w bit indices FW_NZ=1, FW_CV=0.
- Sub-module: condition_check.
  - Pure combinational evaluator.
  - Ports Cond[3:0], Flags[3:0], CondEx.
  - Instantiated once on the flags register.
- cond_unit holds the flags register, the cond_ex_q register and the gating logic.

Test Plan:
1. Reset then idle: after reset, flags=0000, cond_ex_q=0, all gated outputs 0 with pcs=reg_w=mem_w=1. cond=0000 (EQ) -> cond_ex=0; cond=1110 -> cond_ex=1.
2. Flag write:
   - Latch with cond=1110, then flag_w=11, alu_flags=0100 -> flags=0100 next cycle.
   - cond=0001 (NE) -> cond_ex=0; cond=0000 -> cond_ex=1.
3. Partial update: from flags=0100, latched AL, flag_w=01, alu_flags=1011 -> flags=0111 (NZ held, CV updated).
4. Suppressed instruction:
   - flags=0000, cond=0000, cond_latch=1 -> cond_ex_q=0.
   - Then flag_w=11, alu_flags=1111, reg_w=mem_w=pcs=1 -> flags stay 0000, all gated outputs 0.
5. Signed conditions: for flags=1001 (N=V=1), GE=1, LT=0, GT=1, LE=0; for flags=1000, GE=0, LT=1, LE=1.
6. Stall and reset:
   - en=0 with cond_latch=1 and flag_w=11 -> flags and cond_ex_q unchanged.
   - reset asserted with cond_ex_q=1 -> cond_ex_q=0 and flags=RESET_FLAGS next edge.
   - no_write=1 with reg_w=1 -> reg_w_g=0.
